// File: rtl/aes_dec_pipe.sv
// AES-128 decryption core: key-schedule FSM plus 11-stage inverse-cipher pipeline.
// Optional sticky drop_err output is compiled in with AES_DEC_DROP_ERR_EN.
module aes_dec_pipe #(
    parameter int NR = 10,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] IN,
    input  logic [DW-1:0] KEY,
    input  logic          enable,
    input  logic          fsm_en,
    output logic [DW-1:0] OUT,
    output logic          valid_out,
    output logic          key_ready,
`ifdef AES_DEC_DROP_ERR_EN
    output logic          drop_err,
`endif
    output logic [1:0]    dbg_state
);

    // Handshake: enable qualifies IN; a block is taken only on an edge with key_ready=1 and
    // fsm_en=0. There is no backpressure; valid_out is a one-cycle strobe per plaintext block.
    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, READY = 2'd2} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant, built from doublings.
    function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] b2, b4, b8;
        b2 = xt(b);
        b4 = xt(b2);
        b8 = xt(b4);
        return ({8{c[3]}} & b8) ^ ({8{c[2]}} & b4) ^ ({8{c[1]}} & b2) ^ ({8{c[0]}} & b);
    endfunction

    function automatic logic [DW-1:0] next_rk(input logic [DW-1:0] k, input logic [7:0] rc);
        logic [31:0] rot, t, n0, n1, n2, n3;
        rot = {k[23:0], k[31:24]};
        t   = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]} ^ {rc, 24'h0};
        n0  = k[127:96] ^ t;
        n1  = k[95:64] ^ n0;
        n2  = k[63:32] ^ n1;
        n3  = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Byte 0 is the MSB; the state is column-major, so byte 4*c+r sits at row r, column c.
    function automatic logic [DW-1:0] inv_shift(input logic [DW-1:0] s);
        logic [DW-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[DW-1-8*(4*c+r) -: 8] = s[DW-1-8*(4*((c-r)&3)+r) -: 8];
        return o;
    endfunction

    function automatic logic [DW-1:0] inv_sub(input logic [DW-1:0] s);
        logic [DW-1:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
        return o;
    endfunction

    function automatic logic [DW-1:0] inv_mix(input logic [DW-1:0] s);
        logic [DW-1:0] o;
        logic [7:0]    a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[DW-1-32*c -: 32];
            o[DW-1-32*c -: 32] = {
                gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
                gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
                gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
                gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
        end
        return o;
    endfunction

    state_t                 state, state_nx;
    logic [3:0]             cnt;
    logic [NR:0][DW-1:0]    rk;
    logic [NR-1:0][DW-1:0]  st;
    logic [NR-1:0]          v;
    logic                   accept, flush;

    assign key_ready = (state == READY);
    assign dbg_state = state;
    assign flush     = key_ready & fsm_en;
    assign accept    = enable & key_ready & ~fsm_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fsm_en) state_nx = EXPAND;
            EXPAND:  if (cnt == 4'(NR)) state_nx = READY;
            READY:   if (fsm_en) state_nx = EXPAND;
            default: state_nx = IDLE;
        endcase
    end

    // Key schedule: one round key per edge while expanding; fsm_en is only honoured outside EXPAND.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            rk  <= '0;
        end else if (state == EXPAND) begin
            rk[cnt] <= next_rk(rk[cnt - 4'd1], RCON[cnt]);
            cnt     <= cnt + 4'd1;
        end else if (fsm_en) begin
            rk[0] <= KEY;
            cnt   <= 4'd1;
        end
    end

    // A re-key flush kills every in-flight block, including the one about to reach OUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= '0;
            v         <= '0;
            OUT       <= '0;
            valid_out <= 1'b0;
        end else begin
            if (accept) st[0] <= IN ^ rk[NR];
            v[0] <= accept;
            for (int k = 1; k < NR; k++) begin
                st[k] <= inv_mix(inv_sub(inv_shift(st[k-1])) ^ rk[NR-k]);
                v[k]  <= v[k-1] & ~flush;
            end
            valid_out <= v[NR-1] & ~flush;
            if (v[NR-1] && !flush) OUT <= inv_sub(inv_shift(st[NR-1])) ^ rk[0];
        end
    end

`ifdef AES_DEC_DROP_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  drop_err <= 1'b0;
        else if (enable && !accept) drop_err <= 1'b1;
    end
`endif

endmodule
